// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the instruction-memory UART loader and the instruction RAM.
package imem_uart_loader_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned IMEM_AW    = 6;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLen,
    StLoad,
    StCheck,
    StDone,
    StError
  } ld_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection on the start bit.
module imem_uart_loader_uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);

  rx_state_e       state_q, state_d;
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        // Edge, not level, so a line held low after a framing error does not retrigger.
        if (rx_s3_q && !rx_s2_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfBit) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = rx_s2_q;
          ferr_d  = !rx_s2_q;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign data_o       = shift_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Fills the instruction RAM from a UART byte stream: length byte, then N little-endian words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 byte checksum before DONE.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = IMEM_DEPTH,
  parameter int unsigned AW           = IMEM_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          we_o,
  output logic [AW-1:0] wa_o,
  output logic [31:0]   wd_o,
  output logic [AW:0]   words_loaded_o
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e AfterLoad = StCheck;
`else
  localparam ld_state_e AfterLoad = StDone;
`endif

  logic       byte_valid;
  logic [7:0] rx_data;
  logic       frame_err;

  imem_uart_loader_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_valid_o(byte_valid),
    .data_o      (rx_data),
    .frame_err_o (frame_err)
  );

  ld_state_e     state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] wa_q, wa_d;
  logic [23:0]   lane_q, lane_d;
  logic [1:0]    idx_q, idx_d;
  logic          we_q, we_d;
  logic [31:0]   wd_q, wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sum_q <= '0;
    else         sum_q <= sum_d;
  end
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      wa_q    <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    wd_d    = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        // Bytes arriving here are dropped; start has priority over a same-cycle byte.
        if (start_i) begin
          state_d = StWaitLen;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StWaitLen: begin
        if (frame_err) begin
          state_d = StError;
        end else if (byte_valid) begin
          state_d = StLoad;
          cnt_d   = '0;
          wa_d    = '0;
          idx_d   = '0;
          if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) len_d = DepthW;
          else                                         len_d = (AW + 1)'(rx_data);
        end
      end
      StLoad: begin
        if (frame_err) begin
          state_d = StError;
        end else if (we_q) begin
          // Commit the word just written; wa holds on the last word so it never wraps.
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = AfterLoad;
          else                  wa_d    = wa_q + 1'b1;
        end else if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (idx_q == 2'd3) begin
            we_d  = 1'b1;
            wd_d  = {rx_data, lane_q};
            idx_d = '0;
          end else begin
            lane_d = {rx_data, lane_q[23:8]};
            idx_d  = idx_q + 1'b1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (frame_err)       state_d = StError;
        else if (byte_valid) state_d = (rx_data == sum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign busy_o         = (state_q == StWaitLen) || (state_q == StLoad);
  assign done_o         = (state_q == StDone);
  assign err_o          = (state_q == StError);
  assign we_o           = we_q;
  assign wa_o           = wa_q;
  assign wd_o           = wd_q;
  assign words_loaded_o = cnt_q;

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction memory: fills the 64-word instruction RAM from a UART byte stream, replacing the fixed power-up image.
- Contains a UART receiver (8N1), little-endian byte-to-word assembly, and a load FSM that drives a single-cycle write strobe into the instruction RAM write port.
- The core is held in reset externally while busy is high.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 4.
- DEPTH, 64, instruction RAM depth in words.
- AW, 6, write address width; equals clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; idles high; asynchronous to clk.
- start  in  1  one-cycle pulse that arms a load; honoured only in IDLE, DONE or ERROR.
- busy  out  1  high in WAIT_LEN and LOAD.
- done  out  1  high in DONE; held until the next accepted start.
- err  out  1  sticky error; high in ERROR; cleared by an accepted start.
- we  out  1  one-cycle instruction RAM write strobe.
- wa  out  AW  write word address.
- wd  out  32  write data.
- words_loaded  out  AW+1  count of words written in the current load.

Behaviour:
Reset (rst_n low, asynchronous):
- FSM goes to IDLE.
- busy, done, err and we are 0.
- wa, wd and words_loaded are 0.
- UART receiver goes idle; the synchronizer flops are set to 1.

UART receiver:
- rx passes through a 2-flop synchronizer.
- A falling edge in RX_IDLE starts bit timing.
- The start bit is re-sampled at CLKS_PER_BIT/2. If it is high, the event is a glitch and the receiver returns to RX_IDLE without emitting a byte.
- 8 data bits are sampled LSB-first, each CLKS_PER_BIT cycles apart, at bit centre.
- The stop bit is sampled at its centre:
  - stop = 1: a one-cycle byte_valid pulse is emitted with the byte.
  - stop = 0: framing error. No byte is emitted and a one-cycle frame_err pulse is raised.

Load FSM:
- IDLE -> WAIT_LEN on start.
- WAIT_LEN: the first valid byte is the word count N.
  - N = 0 means DEPTH.
  - N > DEPTH is clamped to DEPTH.
  - On that byte, go to LOAD; clear wa, words_loaded and the byte index.
- LOAD: bytes fill lanes b0..b3 in order.
  - On the 4th byte, the next cycle raises we = 1 for exactly 1 cycle, with wd = {b3,b2,b1,b0} and wa = word index.
  - Then words_loaded increments, wa increments and the byte index resets to 0.
  - When words_loaded reaches N: go to CHECK if the checksum feature is compiled in, otherwise to DONE.
- DONE: done = 1. Return to WAIT_LEN on start.
- ERROR: err = 1. Return to WAIT_LEN on start; err and done clear.
- A frame_err pulse in WAIT_LEN, LOAD or CHECK sends the FSM to ERROR. Words already written stay written.
- Bytes arriving in IDLE, DONE or ERROR are discarded. start while busy is ignored.
- wa never exceeds DEPTH-1; the clamp on N guarantees no wrap-around.
- byte_valid and start arriving in the same cycle in DONE: start wins and the byte is discarded.
- rst_n asserted mid-load aborts the load immediately. RAM contents are left partially written.

Latency:
- we rises 1 clk after the byte_valid of the 4th byte of each word.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the N words, the FSM enters CHECK and waits for one trailing byte.
  - If that byte equals the mod-256 sum of all 4N data bytes, go to DONE; otherwise go to ERROR.
  - The running sum clears on entry to WAIT_LEN.
- When undefined:
  - There is no CHECK state and no sum register; the FSM goes to DONE right after the last word write.
  - A trailing byte is discarded as a byte received in DONE.

Decomposition:
- Shared package: loader state enum (IDLE, WAIT_LEN, LOAD, CHECK, DONE, ERROR), UART RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP), and the IMEM_DEPTH = 64 and IMEM_AW = 6 constants used by both the instruction RAM and the loader.
- One sub-module: uart_rx. It takes clk, rst_n and rx, and outputs byte_valid, data[7:0] and frame_err. The loader FSM lives in the top.

Test Plan:
1. start, then bytes 02, 13,00,00,00, 93,00,10,00 -> we pulses at wa=0 with wd=0x00000013 and at wa=1 with wd=0x00100093; words_loaded=2; done=1; err=0.
2. Length byte 00 then 256 bytes -> 64 writes at wa 0..63, with no write at a wrapped address; done=1. Length byte 0x50 -> clamped to 64 writes.
3. Stop bit forced low on the 3rd data byte -> frame_err pulse; state ERROR; err=1; no we for word 0. The next start followed by a clean stream -> done=1 and err=0.
4. A 0.3-bit-wide low glitch on rx in RX_IDLE -> no byte_valid. Bytes sent before start -> no we, state stays IDLE.
5. rst_n pulled low after 5 bytes of an 8-byte load -> all outputs 0 asynchronously, state IDLE. After release with rx high: no activity.
6. With IMEM_LOADER_CHECKSUM_EN, stream 01, 01,02,03,04, checksum 0A -> done=1. The same stream with checksum 0B -> err=1, and the word at wa=0 still equals 0x04030201.
